uart_byte_tx: RTL



---
 rtl/uart_byte_tx.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: a small byte FIFO feeding a start/data/parity/stop frame serializer.
// tx_busy stays high from the first queued byte until the last frame of the burst finishes.
module uart_byte_tx #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    write_data,
    input  logic                          write_en,
    output logic                          tx_busy,
    output logic                          uart_tx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int unsigned BAUD_DIV = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int unsigned CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned PTR_W    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LVL_W    = PTR_W + 1;

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

    if (BAUD_DIV < 2) begin : g_bad_baud
        $error("uart_byte_tx: BAUD_DIV must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_byte_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_byte_tx: PARITY must be 0, 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_byte_tx: FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       frame_q, frame_d;
    logic             tx_q, tx_d;
    logic             busy_q;
    logic             overflow_q;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             bit_end;
    logic             par_bit;

    assign fifo_empty = (level_q == '0);
    assign push       = write_en && (level_q != LVL_FULL);
    assign bit_end    = (baud_cnt_q == BAUD_LAST);

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        pop        = 1'b0;
        if (state_q != StIdle) begin
            baud_cnt_d = bit_end ? '0 : baud_cnt_q + CNT_W'(1);
        end
        unique case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    frame_d = fifo_mem[rd_ptr_q];
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = StData;
                end
            end
            StData: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? StPar : StStop;
                    end
                end
            end
            StPar: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = StStop;
                end
            end
            StStop: begin
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == STOP_LAST) begin
                        // Chain straight into the next start bit so queued frames stay contiguous.
                        bit_cnt_d = '0;
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            frame_d = fifo_mem[rd_ptr_q];
                            state_d = StStart;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign par_bit = (PARITY == 1) ? ~(^frame_d) : (^frame_d);

    // Output bit is derived from the next state so uart_tx lines up with the registered state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = frame_d[bit_cnt_d];
            StPar:   tx_d = par_bit;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            frame_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            frame_q    <= frame_d;
            tx_q       <= tx_d;
            busy_q     <= (state_q != StIdle) || !fifo_empty;
            level_q    <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (write_en && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign uart_tx    = tx_q;
    assign tx_busy    = busy_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule
